// File: rtl/unidad_de_control_multiciclo.sv
// Multicycle MIPS main control FSM: sequences fetch/decode/execute/memory/write-back
// and drives every datapath mux, enable and the 3-bit ALU operation code.
module unidad_de_control_multiciclo (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic       imm_zext,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_source,
  output logic [2:0] alu_op,
  output logic [3:0] state,
  output logic       illegal_op
);

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXEC_R    = 4'd6,
    S_R_WB      = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_EXEC_I    = 4'd10,
    S_I_WB      = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;

  state_t cur_state, nxt_state;
  logic   decode_bad;

  assign state      = cur_state;
  assign decode_bad = (cur_state == S_DECODE) && (nxt_state == S_FETCH);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk) begin
    if (rst) begin
      cur_state  <= S_FETCH;
      illegal_op <= 1'b0;
    end else begin
      cur_state <= nxt_state;
      if (decode_bad) illegal_op <= 1'b1;
    end
  end

  // NOTE: every signal written in an always_comb gets a default first, so no
  // path through the case statement can leave it unassigned and infer a latch.
  always_comb begin
    nxt_state = S_FETCH;
    case (cur_state)
      S_FETCH:     nxt_state = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:                          nxt_state = S_EXEC_R;
          OP_LW, OP_SW:                      nxt_state = S_MEM_ADDR;
          OP_BEQ:                            nxt_state = S_BRANCH;
          OP_J:                              nxt_state = S_JUMP;
          OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: nxt_state = S_EXEC_I;
          default:                           nxt_state = S_FETCH;
        endcase
      end
      S_MEM_ADDR:  nxt_state = (opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
      S_MEM_READ:  nxt_state = mem_ready ? S_MEM_WB : S_MEM_READ;
      S_MEM_WRITE: nxt_state = mem_ready ? S_FETCH : S_MEM_WRITE;
      S_EXEC_R:    nxt_state = S_R_WB;
      S_EXEC_I:    nxt_state = S_I_WB;
      default:     nxt_state = S_FETCH;
    endcase
  end

  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    imm_zext      = 1'b0;
    alu_src_b     = 2'b00;
    pc_source     = 2'b00;
    alu_op        = 3'b000;
    case (cur_state)
      S_FETCH: begin
        // IR and PC only latch once the instruction word has actually arrived.
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      S_DECODE:   alu_src_b = 2'b11;
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_MEM_READ: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEM_WRITE: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
      end
      S_EXEC_R: begin
        alu_src_a = 1'b1;
        alu_op    = 3'b010;
      end
      S_R_WB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = 3'b001;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
      end
      S_JUMP: begin
        pc_write  = 1'b1;
        pc_source = 2'b10;
      end
      S_EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        case (opcode)
          OP_ANDI: begin alu_op = 3'b101; imm_zext = 1'b1; end
          OP_ORI:  begin alu_op = 3'b011; imm_zext = 1'b1; end
          OP_SLTI: alu_op = 3'b100;
          default: alu_op = 3'b000;
        endcase
      end
      S_I_WB: reg_write = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_unidad_de_control_multiciclo.sv
// Bench for unidad_de_control_multiciclo: each instruction is expanded into its expected
// per-cycle (state, controls) script from the instruction-level rules, then replayed.
module tb_unidad_de_control_multiciclo;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic       mem_to_reg, reg_dst, reg_write, alu_src_a, imm_zext;
  logic [1:0] alu_src_b, pc_source;
  logic [2:0] alu_op;
  logic [3:0] state;
  logic       illegal_op;

  unidad_de_control_multiciclo dut (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .imm_zext(imm_zext), .alu_src_b(alu_src_b),
    .pc_source(pc_source), .alu_op(alu_op), .state(state), .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
    logic       mem_to_reg, reg_dst, reg_write, alu_src_a, imm_zext;
    logic [1:0] alu_src_b;
    logic [1:0] pc_source;
    logic [2:0] alu_op;
  } ctl_t;

  typedef struct {
    int   st;
    logic mr;
    logic rs;
    ctl_t c;
  } step_t;

  ctl_t act;
  assign act = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                mem_to_reg, reg_dst, reg_write, alu_src_a, imm_zext,
                alu_src_b, pc_source, alu_op};

  step_t q[$];
  int    n_checks = 0;
  int    n_pass   = 0;
  logic  exp_illegal = 1'b0;

  localparam logic [5:0] LEGAL [9] = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h02,
                                        6'h08, 6'h0C, 6'h0D, 6'h0A};

  function automatic bit is_legal(input logic [5:0] op);
    foreach (LEGAL[i]) if (LEGAL[i] == op) return 1'b1;
    return 1'b0;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic ctl_t fetch_ctl(input logic mr);
    ctl_t c = '0;
    c.mem_read  = 1'b1;
    c.alu_src_b = 2'b01;
    c.ir_write  = mr;
    c.pc_write  = mr;
    return c;
  endfunction

  task automatic push(input int st, input logic mr, input ctl_t c);
    q.push_back('{st: st, mr: mr, rs: 1'b0, c: c});
  endtask

  // Builds the expected cycle-by-cycle script for one instruction, then plays it.
  // abort: the last memory-stall cycle raises rst instead of completing the access.
  task automatic run_instr(input logic [5:0] op, input int fs, input int ms, input bit abort);
    ctl_t c;
    bit   is_store;
    q.delete();
    for (int i = 0; i < fs; i++) push(0, 1'b0, fetch_ctl(1'b0));
    push(0, 1'b1, fetch_ctl(1'b1));
    c = '0; c.alu_src_b = 2'b11;
    push(1, 1'($urandom_range(0, 1)), c);
    case (op)
      6'h00: begin
        c = '0; c.alu_src_a = 1'b1; c.alu_op = 3'b010;
        push(6, 1'($urandom_range(0, 1)), c);
        c = '0; c.reg_write = 1'b1; c.reg_dst = 1'b1;
        push(7, 1'($urandom_range(0, 1)), c);
      end
      6'h23, 6'h2B: begin
        is_store = (op == 6'h2B);
        c = '0; c.alu_src_a = 1'b1; c.alu_src_b = 2'b10;
        push(2, 1'($urandom_range(0, 1)), c);
        c = '0; c.i_or_d = 1'b1;
        if (is_store) c.mem_write = 1'b1; else c.mem_read = 1'b1;
        for (int i = 0; i < ms; i++) push(is_store ? 5 : 3, 1'b0, c);
        if (abort) begin
          q[$].rs = 1'b1;
          push(0, 1'b0, fetch_ctl(1'b0));
        end else begin
          push(is_store ? 5 : 3, 1'b1, c);
          if (!is_store) begin
            c = '0; c.reg_write = 1'b1; c.mem_to_reg = 1'b1;
            push(4, 1'($urandom_range(0, 1)), c);
          end
        end
      end
      6'h04: begin
        c = '0; c.alu_src_a = 1'b1; c.alu_op = 3'b001;
        c.pc_write_cond = 1'b1; c.pc_source = 2'b01;
        push(8, 1'($urandom_range(0, 1)), c);
      end
      6'h02: begin
        c = '0; c.pc_write = 1'b1; c.pc_source = 2'b10;
        push(9, 1'($urandom_range(0, 1)), c);
      end
      6'h08, 6'h0C, 6'h0D, 6'h0A: begin
        c = '0; c.alu_src_a = 1'b1; c.alu_src_b = 2'b10;
        c.alu_op   = (op == 6'h0C) ? 3'b101 : (op == 6'h0D) ? 3'b011 :
                     (op == 6'h0A) ? 3'b100 : 3'b000;
        c.imm_zext = (op == 6'h0C) || (op == 6'h0D);
        push(10, 1'($urandom_range(0, 1)), c);
        c = '0; c.reg_write = 1'b1;
        push(11, 1'($urandom_range(0, 1)), c);
      end
      default: ;
    endcase

    foreach (q[k]) begin
      opcode    = (q[k].st == 0) ? 6'($urandom_range(0, 63)) : op;
      mem_ready = q[k].mr;
      rst       = q[k].rs;
      @(negedge clk);
      check_eq($sformatf("state op=%h cyc=%0d", op, k), 32'(state), 32'(q[k].st));
      check_eq($sformatf("ctl op=%h st=%0d", op, q[k].st), 32'(act), 32'(q[k].c));
      check_eq($sformatf("illegal op=%h cyc=%0d", op, k), 32'(illegal_op), 32'(exp_illegal));
      @(posedge clk);
      if (q[k].rs) exp_illegal = 1'b0;
      else if (q[k].st == 1 && !is_legal(op)) exp_illegal = 1'b1;
      #1;
    end
  endtask

  initial begin
    logic [5:0] op;
    rst = 1'b1; mem_ready = 1'b0; opcode = 6'h00;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check_eq("reset state", 32'(state), 32'd0);
    check_eq("reset illegal", 32'(illegal_op), 32'd0);
    check_eq("reset ctl", 32'(act), 32'(fetch_ctl(1'b0)));
    @(posedge clk);
    #1;

    run_instr(6'h00, 0, 0, 1'b0);   // R-type
    run_instr(6'h23, 0, 2, 1'b0);   // lw with 2-cycle memory stall
    run_instr(6'h0D, 0, 0, 1'b0);   // ori
    run_instr(6'h0A, 0, 0, 1'b0);   // slti
    run_instr(6'h04, 0, 0, 1'b0);   // beq
    run_instr(6'h02, 0, 0, 1'b0);   // j
    run_instr(6'h3F, 0, 0, 1'b0);   // illegal
    run_instr(6'h08, 1, 0, 1'b0);   // addi, illegal_op must stay set
    run_instr(6'h2B, 0, 2, 1'b1);   // sw, reset mid-stall clears everything
    run_instr(6'h0C, 3, 0, 1'b0);   // andi after a 3-cycle fetch stall
    run_instr(6'h2B, 1, 1, 1'b0);   // sw completing after a stall

    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 9) == 0) begin
        do op = 6'($urandom_range(0, 63)); while (is_legal(op));
      end else begin
        op = LEGAL[$urandom_range(0, 8)];
      end
      run_instr(op, $urandom_range(0, 2), $urandom_range(1, 3),
                (op == 6'h23 || op == 6'h2B) && ($urandom_range(0, 4) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
